// File: rtl/hack_mem_pkg.sv
// Shared sizing defaults and requester id type for the hack memory subsystem.
package hack_mem_pkg;

  localparam int ADDR_WIDTH_DEF = 14;
  localparam int DATA_WIDTH_DEF = 16;

  typedef logic req_id_t;

  function automatic req_id_t other_id(input req_id_t id);
    return ~id;
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Two-way pick: a lone requester wins outright, contention is settled by the pointer.
module arb_rr_pick
  import hack_mem_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    pointer,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (pointer == 1'b1) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of a single-port RAM with registered read data.
// Define RAM_ARB_FIXED_PRIO_EN to make requester 0 always win contention.
module ram_arbiter
  import hack_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_in,
  output logic                  ram_load,
  input  logic [DATA_WIDTH-1:0] ram_out
);

  req_id_t               ptr;
  logic [1:0]            pick;
  logic                  granted;
  req_id_t               win_id;
  logic                  win_we;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic [DATA_WIDTH-1:0] last_wdata;
  logic                  rd_valid;
  req_id_t               rd_id;

  arb_rr_pick u_pick (
    .req     ({req1, req0}),
    .pointer (ptr),
    .grant   (pick)
  );

  always_comb begin
    granted   = (pick != 2'b00) && !reset;
    win_id    = pick[1];
    win_we    = win_id ? we1 : we0;
    win_addr  = win_id ? addr1 : addr0;
    win_wdata = win_id ? wdata1 : wdata0;
  end

`ifdef RAM_ARB_FIXED_PRIO_EN
  assign ptr = 1'b0;
`else
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr <= 1'b0;
    end else if (granted) begin
      ptr <= other_id(win_id);
    end
  end
`endif

  // Hold the last granted address/data so the RAM port is quiet while idle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_addr  <= '0;
      last_wdata <= '0;
    end else if (granted) begin
      last_addr  <= win_addr;
      last_wdata <= win_wdata;
    end
  end

  // Read owner: ram_out arrives one cycle after the read grant.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_id    <= 1'b0;
    end else begin
      rd_valid <= granted && !win_we;
      rd_id    <= win_id;
    end
  end

  always_comb begin
    gnt0        = granted && !win_id;
    gnt1        = granted && win_id;
    ram_load    = granted && win_we;
    ram_address = reset ? '0 : (granted ? win_addr : last_addr);
    ram_in      = reset ? '0 : (granted ? win_wdata : last_wdata);
    rvalid0     = rd_valid && !rd_id && !reset;
    rvalid1     = rd_valid && rd_id && !reset;
    rdata0      = rvalid0 ? ram_out : '0;
    rdata1      = rvalid1 ? ram_out : '0;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized bench for ram_arbiter against a transaction-level reference model.
module tb_ram_arbiter;

  localparam int AW = 14;
  localparam int DW = 16;

`ifdef RAM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, ram_load;
  logic [DW-1:0] rdata0, rdata1, ram_in, ram_out;
  logic [AW-1:0] ram_address;

  logic [DW-1:0] ram_mem [0:(1<<AW)-1];

  always #5 clock = ~clock;

  ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .ram_address(ram_address), .ram_in(ram_in), .ram_load(ram_load),
    .ram_out(ram_out)
  );

  // Single-port RAM with registered read port.
  always @(posedge clock) begin
    if (ram_load) ram_mem[ram_address] <= ram_in;
    ram_out <= ram_mem[ram_address];
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model state
  int            favoured;
  logic [DW-1:0] mmem [int];
  logic [AW-1:0] m_last_addr;
  bit            pend_v;
  int            pend_id;
  logic [DW-1:0] pend_data;
  int            m_w;
  logic          obs_g1;

  function automatic logic [DW-1:0] mread(input int a);
    return mmem.exists(a) ? mmem[a] : '0;
  endfunction

  task automatic model_reset();
    favoured    = 0;
    m_last_addr = '0;
    pend_v      = 0;
    pend_id     = 0;
    pend_data   = '0;
  endtask

  task automatic idle();
    req0 = 0; req1 = 0;
  endtask

  // One clock: check outputs mid-cycle against the model, then advance the model.
  task automatic cyc();
    logic          w_we;
    logic [AW-1:0] w_a;
    logic [DW-1:0] w_d;
    @(negedge clock);
    if (req0 && req1)  m_w = favoured;
    else if (req0)     m_w = 0;
    else if (req1)     m_w = 1;
    else               m_w = -1;
    obs_g1 = gnt1;
    check("gnt0", gnt0, m_w == 0);
    check("gnt1", gnt1, m_w == 1);
    check("gnt_mutex", gnt0 & gnt1, 0);
    check("gnt_implies_req", (gnt0 & ~req0) | (gnt1 & ~req1), 0);
    w_we = (m_w == 1) ? we1 : we0;
    w_a  = (m_w == 1) ? addr1 : addr0;
    w_d  = (m_w == 1) ? wdata1 : wdata0;
    if (m_w >= 0) begin
      check("ram_load", ram_load, w_we);
      check("ram_address", ram_address, w_a);
      check("ram_in", ram_in, w_d);
    end else begin
      check("ram_load_idle", ram_load, 0);
      check("ram_address_idle", ram_address, m_last_addr);
    end
    check("rvalid0", rvalid0, pend_v && pend_id == 0);
    check("rvalid1", rvalid1, pend_v && pend_id == 1);
    if (pend_v) check("rdata", (pend_id == 1) ? rdata1 : rdata0, pend_data);
    @(posedge clock);
    pend_v = (m_w >= 0) && !w_we;
    if (m_w >= 0) begin
      pend_id = m_w;
      if (!w_we) pend_data = mread(int'(w_a));
      else       mmem[int'(w_a)] = w_d;
      m_last_addr = w_a;
      favoured = FIXED ? 0 : 1 - m_w;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    @(posedge clock);
    #1 reset = 1'b0;
    model_reset();
  endtask

  logic act [2];
  logic exp_seq [4];

  initial begin
    for (int i = 0; i < (1 << AW); i++) ram_mem[i] = '0;
    model_reset();

    // Outputs forced while reset is high, even with a request pending.
    req0 = 1; we0 = 1; addr0 = 14'h0123; wdata0 = 16'h5A5A;
    #3;
    check("rst_gnt0", gnt0, 0);
    check("rst_gnt1", gnt1, 0);
    check("rst_rvalid", {rvalid1, rvalid0}, 0);
    check("rst_ram_load", ram_load, 0);
    check("rst_ram_address", ram_address, 0);
    check("rst_ram_in", ram_in, 0);
    check("rst_rdata", {rdata1, rdata0}, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    idle();

    // Write then cross-requester read of the same address.
    req0 = 1; we0 = 1; addr0 = 14'h0010; wdata0 = 16'hBEEF;
    cyc();
    req0 = 0; req1 = 1; we1 = 0; addr1 = 14'h0010;
    cyc();
    idle();
    cyc();

    // Held contention of two reads from reset.
    do_reset();
    exp_seq[0] = 0; exp_seq[1] = !FIXED; exp_seq[2] = 0; exp_seq[3] = !FIXED;
    req0 = 1; we0 = 0; addr0 = 14'h0001;
    req1 = 1; we1 = 0; addr1 = 14'h0002;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("rr_seq", obs_g1, exp_seq[i]);
    end

    // Pointer must survive idle cycles.
    cyc();
    check("pre_idle_win", obs_g1, 0);
    idle();
    repeat (3) cyc();
    req0 = 1; req1 = 1;
    cyc();
    check("post_idle_win", obs_g1, !FIXED);
    idle();
    cyc();

    // Reset landing just after a read grant drops the read.
    do_reset();
    req0 = 1; we0 = 0; addr0 = 14'h0010;
    @(negedge clock);
    check("pre_rst_gnt0", gnt0, 1);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("rst_drop_rvalid", {rvalid1, rvalid0}, 0);
    idle();
    @(posedge clock);
    #1 reset = 1'b0;
    model_reset();
    check("post_rst_rvalid", {rvalid1, rvalid0}, 0);
    cyc();
    req0 = 1; req1 = 1; we0 = 0; we1 = 0;
    cyc();
    check("post_rst_win", obs_g1, 0);
    idle();
    cyc();

    // Random traffic; the losing requester holds its request until granted.
    act[0] = 0; act[1] = 0;
    for (int i = 0; i < 400; i++) begin
      if (!act[0]) begin
        act[0] = ($urandom_range(0, 99) < 60);
        we0 = $urandom_range(0, 1); addr0 = AW'($urandom_range(0, 31)); wdata0 = DW'($urandom);
      end
      if (!act[1]) begin
        act[1] = ($urandom_range(0, 99) < 60);
        we1 = $urandom_range(0, 1); addr1 = AW'($urandom_range(0, 31)); wdata1 = DW'($urandom);
      end
      req0 = act[0]; req1 = act[1];
      cyc();
      if (m_w == 0) act[0] = 0;
      if (m_w == 1) act[1] = 0;
    end
    idle();
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
